// File: rtl/armleocpu_icache_responder.sv
// rtl/armleocpu_icache_responder.sv - direct-mapped one-word-per-line instruction cache responder
// Completes fetch commands from the core; misses fill from backing memory, FLUSH_ALL walks all lines.
module armleocpu_icache_responder #(
    parameter int LINES_W = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  c_cmd,
    input  logic [31:0] c_address,
    output logic        c_done,
    output logic [3:0]  c_response,
    output logic [31:0] c_load_data,
    output logic        m_req_valid,
    input  logic        m_req_ready,
    output logic [31:0] m_req_addr,
    input  logic        m_resp_valid,
    input  logic [31:0] m_resp_data,
    input  logic        m_resp_error
);

    localparam int LINES = 1 << LINES_W;
    localparam int TAG_W = 30 - LINES_W;

    localparam logic [3:0] CACHE_CMD_NONE      = 4'd0;
    localparam logic [3:0] CACHE_CMD_EXECUTE   = 4'd1;
    localparam logic [3:0] CACHE_CMD_FLUSH_ALL = 4'd4;

    localparam logic [3:0] CACHE_RESPONSE_SUCCESS     = 4'd0;
    localparam logic [3:0] CACHE_RESPONSE_ACCESSFAULT = 4'd1;
    localparam logic [3:0] CACHE_RESPONSE_MISSALIGNED = 4'd3;
    localparam logic [3:0] CACHE_RESPONSE_UNKNOWNCMD  = 4'd4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RESP,
        S_MREQ,
        S_MWAIT,
        S_FLUSH
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [LINES-1:0]   r_valid;
    logic [TAG_W-1:0]   r_tag  [LINES];
    logic [31:0]        r_data [LINES];
    logic [LINES_W-1:0] r_flush_cnt;
    logic [29:0]        r_addr;

    logic               r_done;
    logic [3:0]         r_response;
    logic [31:0]        r_load_data;

    logic [LINES_W-1:0] w_in_idx;
    logic [TAG_W-1:0]   w_in_tag;
    logic [LINES_W-1:0] w_fill_idx;
    logic [TAG_W-1:0]   w_fill_tag;
    logic               w_hit;
    logic               w_accept;
    logic               w_fill;
    logic               w_flush_start;
    logic               w_flush_clr;
    logic               w_done_nxt;
    logic [3:0]         w_response_nxt;
    logic [31:0]        w_load_data_nxt;

    // Lookup uses the live command address; fills use the word address latched at accept.
    assign w_in_idx   = c_address[LINES_W+1:2];
    assign w_in_tag   = c_address[31:LINES_W+2];
    assign w_fill_idx = r_addr[LINES_W-1:0];
    assign w_fill_tag = r_addr[29:LINES_W];
    assign w_hit      = r_valid[w_in_idx] && (r_tag[w_in_idx] == w_in_tag);
    assign w_accept   = (r_state == S_IDLE) || (r_state == S_RESP);

    assign c_done      = r_done;
    assign c_response  = r_response;
    assign c_load_data = r_load_data;
    assign m_req_valid = (r_state == S_MREQ);
    assign m_req_addr  = {r_addr, 2'b00};

    always_comb begin
        w_state_nxt     = r_state;
        w_done_nxt      = 1'b0;
        w_response_nxt  = CACHE_RESPONSE_SUCCESS;
        w_load_data_nxt = 32'd0;
        w_fill          = 1'b0;
        w_flush_start   = 1'b0;
        w_flush_clr     = 1'b0;
        case (r_state)
            S_IDLE, S_RESP: begin
                case (c_cmd)
                    CACHE_CMD_NONE: begin
                        w_state_nxt = S_IDLE;
                    end
                    CACHE_CMD_EXECUTE: begin
                        if (c_address[1:0] != 2'b00) begin
                            w_state_nxt    = S_RESP;
                            w_done_nxt     = 1'b1;
                            w_response_nxt = CACHE_RESPONSE_MISSALIGNED;
                        end else if (w_hit) begin
                            w_state_nxt     = S_RESP;
                            w_done_nxt      = 1'b1;
                            w_load_data_nxt = r_data[w_in_idx];
                        end else begin
                            w_state_nxt = S_MREQ;
                        end
                    end
                    CACHE_CMD_FLUSH_ALL: begin
                        w_state_nxt   = S_FLUSH;
                        w_flush_start = 1'b1;
                    end
                    default: begin
                        w_state_nxt    = S_RESP;
                        w_done_nxt     = 1'b1;
                        w_response_nxt = CACHE_RESPONSE_UNKNOWNCMD;
                    end
                endcase
            end
            S_MREQ: begin
                if (m_req_ready) begin
                    w_state_nxt = S_MWAIT;
                end
            end
            S_MWAIT: begin
                if (m_resp_valid) begin
                    w_state_nxt = S_RESP;
                    w_done_nxt  = 1'b1;
                    if (m_resp_error) begin
                        w_response_nxt = CACHE_RESPONSE_ACCESSFAULT;
                    end else begin
                        w_fill          = 1'b1;
                        w_load_data_nxt = m_resp_data;
                    end
                end
            end
            S_FLUSH: begin
                w_flush_clr = 1'b1;
                if (r_flush_cnt == LINES_W'(LINES - 1)) begin
                    w_state_nxt = S_RESP;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_valid     <= '0;
            r_flush_cnt <= '0;
            r_addr      <= '0;
            r_done      <= 1'b0;
            r_response  <= CACHE_RESPONSE_SUCCESS;
            r_load_data <= 32'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_done      <= w_done_nxt;
            r_response  <= w_response_nxt;
            r_load_data <= w_load_data_nxt;
            if (w_accept) begin
                r_addr <= c_address[31:2];
            end
            if (w_flush_start) begin
                r_flush_cnt <= '0;
            end else if (r_state == S_FLUSH) begin
                r_flush_cnt <= r_flush_cnt + LINES_W'(1);
            end
            if (w_fill) begin
                r_valid[w_fill_idx] <= 1'b1;
            end
            if (w_flush_clr) begin
                r_valid[r_flush_cnt] <= 1'b0;
            end
        end
    end

    // Line payload needs no reset: a line is only ever read while its valid bit is set.
    always_ff @(posedge clk) begin
        if (rst_n && w_fill) begin
            r_tag[w_fill_idx]  <= w_fill_tag;
            r_data[w_fill_idx] <= m_resp_data;
        end
    end

endmodule
